// File: rtl/sap_ctrl_seq.sv
// Control sequencer for the 8-bit bus machine: a six-state one-hot ring counter
// plus opcode decode that drives every load/enable strobe.
module sap_ctrl_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       halt,
  output logic [5:0] t_state,
  output logic       instr_done,
  output logic [7:0] instr_cnt
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e   state_q, state_d;
  logic       halt_q, halt_d;
  logic [7:0] instr_cnt_q, instr_cnt_d;
  logic       active;

  // clr also gates the strobes so nothing is driven while reset is held.
  assign active = clr & run & ~halt_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= T1;
      halt_q      <= 1'b0;
      instr_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_d      = halt_q;
    instr_cnt_d = instr_cnt_q;
    cp          = 1'b0;
    ep          = 1'b0;
    lm          = 1'b0;
    ce          = 1'b0;
    li          = 1'b0;
    ei          = 1'b0;
    la          = 1'b0;
    ea          = 1'b0;
    su          = 1'b0;
    eu          = 1'b0;
    lb          = 1'b0;
    lo          = 1'b0;
    instr_done  = 1'b0;
    if (active) begin
      case (state_q)
        T1: begin
          ep      = 1'b1;
          lm      = 1'b1;
          state_d = T2;
        end
        T2: begin
          cp      = 1'b1;
          state_d = T3;
        end
        T3: begin
          ce      = 1'b1;
          li      = 1'b1;
          state_d = T4;
        end
        T4: begin
          state_d = T5;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei = 1'b1;
              lm = 1'b1;
            end
            OP_OUT: begin
              ea = 1'b1;
              lo = 1'b1;
            end
            OP_HLT: begin
              halt_d  = 1'b1;
              state_d = T4;
            end
            default: ;
          endcase
        end
        T5: begin
          state_d = T6;
          case (opcode)
            OP_LDA: begin
              ce = 1'b1;
              la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ce = 1'b1;
              lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          state_d     = T1;
          instr_done  = 1'b1;
          instr_cnt_d = instr_cnt_q + 8'd1;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        // An illegal encoding recovers to the start of a fetch.
        default: state_d = T1;
      endcase
    end
  end

  assign t_state   = state_q;
  assign halt      = halt_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Directed bench for sap_ctrl_seq: fetch, LDA/SUB/ADD/OUT execute, pause,
// halt, reset release and instr_cnt wrap, with bus exclusivity on every cycle.
module tb_sap_ctrl_seq;

  logic       clk;
  logic       clr;
  logic       run;
  logic [3:0] opcode;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic       halt;
  logic [5:0] t_state;
  logic       instr_done;
  logic [7:0] instr_cnt;
  logic [11:0] strb;

  int checks;
  int errors;

  // Strobe vector bit positions: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] S_CP = 12'h800;
  localparam logic [11:0] S_EP = 12'h400;
  localparam logic [11:0] S_LM = 12'h200;
  localparam logic [11:0] S_CE = 12'h100;
  localparam logic [11:0] S_LI = 12'h080;
  localparam logic [11:0] S_EI = 12'h040;
  localparam logic [11:0] S_LA = 12'h020;
  localparam logic [11:0] S_EA = 12'h010;
  localparam logic [11:0] S_SU = 12'h008;
  localparam logic [11:0] S_EU = 12'h004;
  localparam logic [11:0] S_LB = 12'h002;
  localparam logic [11:0] S_LO = 12'h001;
  localparam logic [11:0] S_NONE = 12'h000;

  localparam logic [5:0] ST1 = 6'b000001;
  localparam logic [5:0] ST2 = 6'b000010;
  localparam logic [5:0] ST3 = 6'b000100;
  localparam logic [5:0] ST4 = 6'b001000;
  localparam logic [5:0] ST5 = 6'b010000;
  localparam logic [5:0] ST6 = 6'b100000;

  assign strb = {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};

  sap_ctrl_seq dut (
    .clk        (clk),
    .clr        (clr),
    .run        (run),
    .opcode     (opcode),
    .cp         (cp),
    .ep         (ep),
    .lm         (lm),
    .ce         (ce),
    .li         (li),
    .ei         (ei),
    .la         (la),
    .ea         (ea),
    .su         (su),
    .eu         (eu),
    .lb         (lb),
    .lo         (lo),
    .halt       (halt),
    .t_state    (t_state),
    .instr_done (instr_done),
    .instr_cnt  (instr_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, settle, then check the bus exclusivity invariant.
  task automatic step();
    @(posedge clk);
    #2;
    checks++;
    assert ($countones({ep, ce, ei, ea, eu}) <= 1)
    else begin
      errors++;
      $error("FAIL bus_excl observed=%b expected=at most one of ep,ce,ei,ea,eu",
             {ep, ce, ei, ea, eu});
    end
  endtask

  task automatic expect_state(input string tag, input logic [5:0] exp_t,
                              input logic [11:0] exp_s, input logic exp_done);
    checks++;
    assert (t_state === exp_t)
    else begin
      errors++;
      $error("FAIL %s_t_state observed=%b expected=%b", tag, t_state, exp_t);
    end
    checks++;
    assert (strb === exp_s)
    else begin
      errors++;
      $error("FAIL %s_strobes observed=%h expected=%h", tag, strb, exp_s);
    end
    checks++;
    assert (instr_done === exp_done)
    else begin
      errors++;
      $error("FAIL %s_done observed=%b expected=%b", tag, instr_done, exp_done);
    end
  endtask

  task automatic expect_cnt(input string tag, input logic [7:0] exp_c);
    checks++;
    assert (instr_cnt === exp_c)
    else begin
      errors++;
      $error("FAIL %s_cnt observed=%0d expected=%0d", tag, instr_cnt, exp_c);
    end
  endtask

  task automatic expect_halt(input string tag, input logic exp_h);
    checks++;
    assert (halt === exp_h)
    else begin
      errors++;
      $error("FAIL %s_halt observed=%b expected=%b", tag, halt, exp_h);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr    = 1'b0;
    run    = 1'b1;
    opcode = 4'h0;

    // Reset held with run=1: T1 strobes must still be suppressed.
    step();
    step();
    expect_state("rst", ST1, S_NONE, 1'b0);
    expect_halt("rst", 1'b0);
    expect_cnt("rst", 8'd0);

    // Release: T1 strobes visible before the first edge.
    clr = 1'b1;
    #1;
    expect_state("lda_t1", ST1, S_EP | S_LM, 1'b0);
    step(); expect_state("lda_t2", ST2, S_CP, 1'b0);
    step(); expect_state("lda_t3", ST3, S_CE | S_LI, 1'b0);
    step(); expect_state("lda_t4", ST4, S_EI | S_LM, 1'b0);
    step(); expect_state("lda_t5", ST5, S_CE | S_LA, 1'b0);
    step(); expect_state("lda_t6", ST6, S_NONE, 1'b1);
    expect_cnt("lda_t6", 8'd0);
    step(); expect_state("lda_end", ST1, S_EP | S_LM, 1'b0);
    expect_cnt("lda_end", 8'd1);

    // SUB
    opcode = 4'h2;
    step(); step();
    step(); expect_state("sub_t4", ST4, S_EI | S_LM, 1'b0);
    step(); expect_state("sub_t5", ST5, S_CE | S_LB, 1'b0);
    step(); expect_state("sub_t6", ST6, S_EU | S_LA | S_SU, 1'b1);
    step(); expect_cnt("sub_end", 8'd2);

    // ADD: same sequence, su stays low
    opcode = 4'h1;
    step(); step();
    step(); expect_state("add_t4", ST4, S_EI | S_LM, 1'b0);
    step(); expect_state("add_t5", ST5, S_CE | S_LB, 1'b0);
    step(); expect_state("add_t6", ST6, S_EU | S_LA, 1'b1);
    step(); expect_cnt("add_end", 8'd3);

    // OUT with a 3-cycle pause in T4
    opcode = 4'hE;
    step(); step(); step();
    run = 1'b0;
    #1;
    expect_state("out_pause0", ST4, S_NONE, 1'b0);
    step(); expect_state("out_pause1", ST4, S_NONE, 1'b0);
    step(); expect_state("out_pause2", ST4, S_NONE, 1'b0);
    step(); expect_state("out_pause3", ST4, S_NONE, 1'b0);
    run = 1'b1;
    #1;
    expect_state("out_t4", ST4, S_EA | S_LO, 1'b0);
    step(); expect_state("out_t5", ST5, S_NONE, 1'b0);
    step(); expect_state("out_t6", ST6, S_NONE, 1'b1);
    step(); expect_cnt("out_end", 8'd4);

    // HLT
    opcode = 4'hF;
    step(); step();
    step(); expect_state("hlt_t4", ST4, S_NONE, 1'b0);
    expect_halt("hlt_t4", 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_state("hlt_hold", ST4, S_NONE, 1'b0);
      expect_halt("hlt_hold", 1'b1);
      expect_cnt("hlt_hold", 8'd4);
    end

    // Asynchronous clear away from any clock edge
    clr = 1'b0;
    #1;
    expect_state("hlt_clr", ST1, S_NONE, 1'b0);
    expect_halt("hlt_clr", 1'b0);
    expect_cnt("hlt_clr", 8'd0);
    step();
    clr = 1'b1;

    // 256 NOPs wrap the retire counter
    opcode = 4'h7;
    #1;
    expect_state("nop_t1", ST1, S_EP | S_LM, 1'b0);
    for (int i = 0; i < 256; i++) begin
      step(); step(); step();
      if (i == 0) expect_state("nop_t4", ST4, S_NONE, 1'b0);
      step(); step();
      if (i == 0) expect_state("nop_t6", ST6, S_NONE, 1'b1);
      step();
      if (i == 254) expect_cnt("nop_255", 8'd255);
    end
    expect_cnt("nop_wrap", 8'd0);
    expect_state("nop_end", ST1, S_EP | S_LM, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
